dus_stream_core: RTL and testbench
==================================

Name: dus_stream_core

Overview:
- Hand-written, parametrised replacement for the HLS-generated image downsampler core.
- Reads a row-major IMG_H x IMG_W image from a single-port memory (img_*) and writes the (IMG_H/FACTOR) x (IMG_W/FACTOR) result to a second single-port memory (dus_*).
- Keeps the ap_ctrl_hs start/done/ready/idle handshake and the *_ce0/*_we0/*_address0/*_d0/*_q0 memory port style, so it drops into the existing top-level wrappers.
- Adds arbitrary image size, arbitrary power-of-two factor, a fully pipelined 1-sample/cycle datapath and optional box averaging.

Parameters:
- DATA_W, 32, pixel width in bits.
- IMG_H, 32, input image rows.
- IMG_W, 32, input image columns.
- FACTOR, 2, downsample factor in both dimensions. Must be a power of two >= 1.
- IMG_AW, $clog2(IMG_H*IMG_W), img address width.
- DUS_AW, $clog2((IMG_H/FACTOR)*(IMG_W/FACTOR)), dus address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ap_start  in  1  start request, sampled in IDLE only
- ap_done  out  1  one-cycle pulse when the last dus write has completed
- ap_ready  out  1  one-cycle pulse, same cycle as ap_done
- ap_idle  out  1  high while in IDLE
- img_ce0  out  1  img read enable
- img_we0  out  1  tied 0
- img_address0  out  IMG_AW  img read address
- img_d0  out  DATA_W  tied 0
- img_q0  in  DATA_W  read data, valid one cycle after img_ce0
- dus_ce0  out  1  dus enable
- dus_we0  out  1  dus write enable
- dus_address0  out  DUS_AW  dus write address
- dus_d0  out  DATA_W  dus write data
- dus_q0  in  DATA_W  unused, kept for interface compatibility

Behaviour:
- Elaboration checks: IMG_H % FACTOR == 0, IMG_W % FACTOR == 0, FACTOR power of two; any violation is a fatal error.
- Derived values: OH = IMG_H/FACTOR; OW = IMG_W/FACTOR; N = OH*OW; S = samples per output (1, or FACTOR*FACTOR with averaging); R = N*S.
- Reset values (rst high at a clock edge, from any state, mid-run included):
  - State goes to IDLE; all counters and the accumulator clear.
  - ap_idle = 1; ap_done = ap_ready = 0.
  - All ce/we = 0; addresses = 0; dus_d0 = 0.
  - No memory access occurs in the cycle after reset.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN when ap_start = 1.
  - RUN issues one img read per cycle for R cycles; RUN -> DRAIN after the R-th read.
  - DRAIN performs the final write; DRAIN -> DONE.
  - DONE pulses ap_done and ap_ready; DONE -> IDLE unconditionally.
  - ap_start is ignored outside IDLE. A start held high through DONE begins a new run from the IDLE cycle that follows.
- Read order: output row oy, output column ox, then (with averaging) sub-row dy, sub-column dx.
  - img_address0 = (oy*FACTOR+dy)*IMG_W + ox*FACTOR + dx.
  - Addresses are generated by incremental counters/adders; no multipliers.
- Write timing: a dus write (dus_ce0 = dus_we0 = 1) occurs exactly one cycle after the last read of its output pixel.
  - dus_address0 = oy*OW + ox, incrementing from 0 to N-1.
  - dus_ce0 and dus_we0 are otherwise 0.
- Latency: cycle 0 is the edge that samples ap_start.
  - Reads occur in cycles 1..R.
  - Last write occurs in cycle R+1.
  - ap_done occurs in cycle R+2.
  - ap_idle is low in cycles 1..R+2.
- Decimation (default): dus_d0 = img_q0 of the top-left sample (dy = dx = 0).

Optional Feature:
- Macro: DUS_STREAM_AVG_EN.
- When defined: S = FACTOR*FACTOR.
  - Accumulator width is DATA_W + 2*log2(FACTOR), unsigned; it is cleared at the first sample of each block.
  - dus_d0 = acc >> 2*log2(FACTOR), i.e. truncating unsigned mean, with no overflow at all-ones input.
- When undefined: pure decimation, S = 1; no accumulator hardware is instantiated.

Decomposition:
- dus_pkg contains:
  - the state enum typedef (IDLE, RUN, DRAIN, DONE);
  - the localparam helpers for OH, OW, N, S and the shift amount;
  - the elaboration check function.
- One sub-module, dus_addr_gen: holds the nested oy/ox/dy/dx counters and produces the img address, the dus address, and first/last-sample flags.
- The top level holds the FSM, the one-cycle read-latency alignment register and the accumulator.

Test Plan:
- Default parameters, decimation, img[a] = a, start pulse -> dus[0] = 0, dus[1] = 2, dus[16] = 64, dus[255] = 990; exactly 256 writes; ap_done in cycle 258; ap_idle low in cycles 1..258.
- DUS_STREAM_AVG_EN, default parameters, same ramp -> dus[0] = 16, dus[255] = 1006; 1024 reads; ap_done in cycle 1026.
- IMG_H = 8, IMG_W = 16, FACTOR = 4, averaging, all pixels 32'hFFFFFFFF -> 8 writes, each 32'hFFFFFFFF, addresses 0..7, with no overflow.
- ap_start held high continuously -> a second run begins reading in cycle 260 (start sampled in IDLE cycle 259), with an identical write sequence.
- rst asserted in cycle 100 of a run -> from cycle 101 ce/we = 0 and ap_idle = 1, no ap_done pulse; a new start then produces a complete correct result.
- ap_start pulsed during RUN and DONE -> ignored: no extra run, and exactly one ap_done pulse.

Source files
------------

// File: rtl/dus_pkg.sv
// dus_pkg: state type, geometry helpers and configuration check shared by the downsampler core.
package dus_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} dus_state_e;

    function automatic int dus_oh(input int h, input int f);
        return h / f;
    endfunction

    function automatic int dus_ow(input int w, input int f);
        return w / f;
    endfunction

    function automatic int dus_n(input int h, input int w, input int f);
        return (h / f) * (w / f);
    endfunction

    function automatic int dus_s(input int f, input bit avg);
        return avg ? f * f : 1;
    endfunction

    function automatic int dus_shift(input int f, input bit avg);
        return avg ? 2 * $clog2(f) : 0;
    endfunction

    function automatic int dus_cw(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

    function automatic bit dus_cfg_ok(input int h, input int w, input int f);
        return f >= 1 && (f & (f - 1)) == 0 && h % f == 0 && w % f == 0;
    endfunction

endpackage

// File: rtl/dus_addr_gen.sv
// dus_addr_gen: nested oy/ox/dy/dx read counters producing img/dus addresses incrementally.
module dus_addr_gen
    import dus_pkg::*;
#(
    parameter int IMG_H  = 32,
    parameter int IMG_W  = 32,
    parameter int FACTOR = 2,
    parameter int SUB    = 1,
    parameter int IMG_AW = 10,
    parameter int DUS_AW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adv_i,
    output logic [IMG_AW-1:0] img_addr_o,
    output logic [DUS_AW-1:0] dus_addr_o,
    output logic              first_o,
    output logic              last_o,
    output logic              end_o
);

    localparam int OH = dus_oh(IMG_H, FACTOR);
    localparam int OW = dus_ow(IMG_W, FACTOR);
    localparam int DW = dus_cw(SUB);
    localparam int XW = dus_cw(OW);
    localparam int YW = dus_cw(OH);
    // Address deltas for each counter wrap; negative steps rely on modulo-2^IMG_AW wrap.
    localparam logic [IMG_AW-1:0] STEP_DY = IMG_AW'(IMG_W - (SUB - 1));
    localparam logic [IMG_AW-1:0] STEP_OX = IMG_AW'(FACTOR - (SUB - 1) * (IMG_W + 1));
    localparam logic [IMG_AW-1:0] STEP_OY = IMG_AW'((FACTOR - SUB) * IMG_W + FACTOR - SUB + 1);

    logic [DW-1:0]     dx_q, dy_q;
    logic [XW-1:0]     ox_q;
    logic [YW-1:0]     oy_q;
    logic [IMG_AW-1:0] img_q;
    logic [DUS_AW-1:0] dus_q;
    logic              dx_end, dy_end, ox_end, oy_end;

    assign dx_end     = dx_q == DW'(SUB - 1);
    assign dy_end     = dy_q == DW'(SUB - 1);
    assign ox_end     = ox_q == XW'(OW - 1);
    assign oy_end     = oy_q == YW'(OH - 1);
    assign first_o    = dx_q == '0 && dy_q == '0;
    assign last_o     = dx_end && dy_end;
    assign end_o      = last_o && ox_end && oy_end;
    assign img_addr_o = img_q;
    assign dus_addr_o = dus_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dx_q  <= '0;
            dy_q  <= '0;
            ox_q  <= '0;
            oy_q  <= '0;
            img_q <= '0;
            dus_q <= '0;
        end else if (adv_i) begin
            dx_q  <= dx_end ? '0 : dx_q + DW'(1);
            dy_q  <= !dx_end ? dy_q : dy_end ? '0 : dy_q + DW'(1);
            ox_q  <= !last_o ? ox_q : ox_end ? '0 : ox_q + XW'(1);
            oy_q  <= !(last_o && ox_end) ? oy_q : oy_end ? '0 : oy_q + YW'(1);
            dus_q <= !last_o ? dus_q : end_o ? '0 : dus_q + DUS_AW'(1);
            img_q <= end_o ? '0 : !dx_end ? img_q + IMG_AW'(1) : !dy_end ? img_q + STEP_DY :
                     !ox_end ? img_q + STEP_OX : img_q + STEP_OY;
        end
    end

endmodule

// File: rtl/dus_stream_core.sv
// dus_stream_core: ap_ctrl_hs image downsampler, one img read per cycle, decimation by default.
// Define DUS_STREAM_AVG_EN to replace decimation with a truncating FACTOR x FACTOR box average.
module dus_stream_core
    import dus_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMG_H  = 32,
    parameter int IMG_W  = 32,
    parameter int FACTOR = 2,
    parameter int IMG_AW = $clog2(IMG_H * IMG_W),
    parameter int DUS_AW = $clog2((IMG_H / FACTOR) * (IMG_W / FACTOR))
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_ready,
    output logic              ap_idle,
    output logic              img_ce0,
    output logic              img_we0,
    output logic [IMG_AW-1:0] img_address0,
    output logic [DATA_W-1:0] img_d0,
    input  logic [DATA_W-1:0] img_q0,
    output logic              dus_ce0,
    output logic              dus_we0,
    output logic [DUS_AW-1:0] dus_address0,
    output logic [DATA_W-1:0] dus_d0,
    input  logic [DATA_W-1:0] dus_q0
);

`ifdef DUS_STREAM_AVG_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif
    localparam int SUB = AVG ? FACTOR : 1;
    localparam int SH  = dus_shift(FACTOR, AVG);

    if (!dus_cfg_ok(IMG_H, IMG_W, FACTOR)) begin : g_bad_cfg
        $fatal(1, "dus_stream_core: FACTOR must be a power of two dividing IMG_H and IMG_W");
    end

    dus_state_e        state_q, state_d;
    logic              rd, first, last, fin, wr;
    logic              vld_q, first_q, last_q;
    logic [DUS_AW-1:0] dus_addr, dus_addr_q;
    logic [DATA_W-1:0] dus_d;

    dus_addr_gen #(
        .IMG_H (IMG_H),
        .IMG_W (IMG_W),
        .FACTOR(FACTOR),
        .SUB   (SUB),
        .IMG_AW(IMG_AW),
        .DUS_AW(DUS_AW)
    ) u_addr (
        .clk       (clk),
        .rst       (rst),
        .adv_i     (rd),
        .img_addr_o(img_address0),
        .dus_addr_o(dus_addr),
        .first_o   (first),
        .last_o    (last),
        .end_o     (fin)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = ap_start ? RUN : IDLE;
            RUN:     state_d = fin ? DRAIN : RUN;
            DRAIN:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Read-side flags delayed one cycle to line up with img_q0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            vld_q      <= 1'b0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            dus_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            vld_q      <= rd;
            first_q    <= first;
            last_q     <= last;
            dus_addr_q <= dus_addr;
        end
    end

    assign rd           = state_q == RUN;
    assign wr           = vld_q && last_q;
    assign ap_idle      = state_q == IDLE;
    assign ap_done      = state_q == DONE;
    assign ap_ready     = ap_done;
    assign img_ce0      = rd;
    assign img_we0      = 1'b0;
    assign img_d0       = '0;
    assign dus_ce0      = wr;
    assign dus_we0      = wr;
    assign dus_address0 = wr ? dus_addr_q : '0;
    assign dus_d0       = wr ? dus_d : '0;

`ifdef DUS_STREAM_AVG_EN
    localparam int AW = DATA_W + SH;
    logic [AW-1:0] acc_q, sum;
    logic          unused_w;

    // The block's first sample restarts the sum rather than adding to the previous block.
    assign sum      = (first_q ? '0 : acc_q) + AW'(img_q0);
    assign dus_d    = DATA_W'(sum >> SH);
    assign unused_w = ^dus_q0;

    always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else if (vld_q) acc_q <= sum;
    end
`else
    logic unused_w;

    assign dus_d    = img_q0;
    assign unused_w = ^{dus_q0, first_q};
`endif

endmodule

// File: tb/tb_dus_stream_core.sv
// tb_dus_stream_core: cycle-level model check of dus_stream_core with default geometry.
// Expectations follow DUS_STREAM_AVG_EN when the bench is built with it defined.
module tb_dus_stream_core;

    localparam int DATA_W = 32;
    localparam int IMG_H  = 32;
    localparam int IMG_W  = 32;
    localparam int F      = 2;
    localparam int OH     = IMG_H / F;
    localparam int OW     = IMG_W / F;
    localparam int N      = OH * OW;
`ifdef DUS_STREAM_AVG_EN
    localparam int SUB = F;
`else
    localparam int SUB = 1;
`endif
    localparam int S      = SUB * SUB;
    localparam int R      = N * S;
    localparam int IMG_AW = $clog2(IMG_H * IMG_W);
    localparam int DUS_AW = $clog2(N);

    logic              clk = 1'b0, rst = 1'b1, ap_start = 1'b0;
    logic              ap_done, ap_ready, ap_idle;
    logic              img_ce0, img_we0, dus_ce0, dus_we0;
    logic [IMG_AW-1:0] img_address0;
    logic [DUS_AW-1:0] dus_address0;
    logic [DATA_W-1:0] img_d0, dus_d0;
    logic [DATA_W-1:0] img_q0 = '0;
    logic [DATA_W-1:0] dus_q0 = '0;

    logic [DATA_W-1:0] img_mem [IMG_H*IMG_W];
    logic [DATA_W-1:0] exp_dus [N];
    logic [DATA_W-1:0] dus_mem [N];

    int checks = 0, fails = 0;
    int c = 0, cyc = 0, ref_cyc = 0, wr_cnt = 0, rd_cnt = 0;
    int rd_begin_q[$], done_q[$];
    logic prev_ce = 1'b0;

    always #5 clk = ~clk;

    dus_stream_core dut (
        .clk         (clk),
        .rst         (rst),
        .ap_start    (ap_start),
        .ap_done     (ap_done),
        .ap_ready    (ap_ready),
        .ap_idle     (ap_idle),
        .img_ce0     (img_ce0),
        .img_we0     (img_we0),
        .img_address0(img_address0),
        .img_d0      (img_d0),
        .img_q0      (img_q0),
        .dus_ce0     (dus_ce0),
        .dus_we0     (dus_we0),
        .dus_address0(dus_address0),
        .dus_d0      (dus_d0),
        .dus_q0      (dus_q0)
    );

    always @(posedge clk) if (img_ce0) img_q0 <= img_mem[img_address0];

    // c is the cycle number (relative to the start-sampling edge) of the upcoming edge; 0 = idle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) c <= 0;
        else if (c == 0) c <= ap_start ? 1 : 0;
        else c <= (c == R + 2) ? 0 : c + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int rd_addr(input int j);
        int blk = j / S;
        int s   = j % S;
        return ((blk / OW) * F + s / SUB) * IMG_W + (blk % OW) * F + s % SUB;
    endfunction

    always @(negedge clk) begin : cmp
        bit rd_e, wr_e;
        int wa;
        rd_e = c >= 1 && c <= R;
        wr_e = c >= 2 && c <= R + 1 && (c - 1) % S == 0;
        wa   = (c - 1) / S - 1;
        chk("ap_idle", 64'(ap_idle), 64'(c == 0));
        chk("ap_done", 64'(ap_done), 64'(c == R + 2));
        chk("ap_ready", 64'(ap_ready), 64'(c == R + 2));
        chk("img_ce0", 64'(img_ce0), 64'(rd_e));
        chk("img_we0/img_d0", 64'({img_we0, img_d0}), 64'd0);
        if (rd_e) chk("img_address0", 64'(img_address0), 64'(rd_addr(c - 1)));
        chk("dus_ce0", 64'(dus_ce0), 64'(wr_e));
        chk("dus_we0", 64'(dus_we0), 64'(wr_e));
        if (wr_e) begin
            chk("dus_address0", 64'(dus_address0), 64'(wa));
            chk("dus_d0", 64'(dus_d0), 64'(exp_dus[wa]));
        end
        if (dus_ce0 && dus_we0) begin
            dus_mem[dus_address0] = dus_d0;
            wr_cnt++;
        end
        if (img_ce0) rd_cnt++;
        if (img_ce0 && !prev_ce) rd_begin_q.push_back(cyc + 1 - ref_cyc);
        prev_ce = img_ce0;
        if (ap_done) done_q.push_back(cyc + 1 - ref_cyc);
    end

    task automatic fill(input int kind);
        for (int a = 0; a < IMG_H * IMG_W; a++)
            img_mem[a] = kind == 0 ? DATA_W'(a) : kind == 1 ? '1 :
                         (DATA_W'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
        for (int oy = 0; oy < OH; oy++)
            for (int ox = 0; ox < OW; ox++) begin
                longint unsigned sum = 0;
                for (int dy = 0; dy < SUB; dy++)
                    for (int dx = 0; dx < SUB; dx++)
                        sum += 64'(img_mem[(oy * F + dy) * IMG_W + ox * F + dx]);
                exp_dus[oy * OW + ox] = DATA_W'(sum / 64'(S));
            end
    endtask

    task automatic start_run(input bit hold);
        for (int i = 0; i < N; i++) dus_mem[i] = '0;
        wr_cnt = 0;
        rd_cnt = 0;
        rd_begin_q.delete();
        done_q.delete();
        ref_cyc  = cyc + 1;
        ap_start = 1'b1;
        @(posedge clk); #1;
        if (!hold) ap_start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!ap_done && n < R + 50) begin
            @(negedge clk);
            n++;
        end
        chk("ap_done within bound", 64'(ap_done), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_run(input int runs);
        int bad = 0;
        for (int i = 0; i < N; i++) if (dus_mem[i] !== exp_dus[i]) bad++;
        chk("dus image mismatches", 64'(bad), 64'd0);
        chk("write count", 64'(wr_cnt), 64'(runs * N));
        chk("read count", 64'(rd_cnt), 64'(runs * R));
        chk("ap_done pulses", 64'(done_q.size()), 64'(runs));
        chk("first read cycle", 64'(rd_begin_q.size() > 0 ? rd_begin_q[0] : -1), 64'd1);
        chk("ap_done cycle", 64'(done_q.size() > 0 ? done_q[0] : -1), 64'(R + 2));
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, " img_address0"}, 64'(img_address0), 64'd0);
        chk({tag, " dus_address0"}, 64'(dus_address0), 64'd0);
        chk({tag, " dus_d0"}, 64'(dus_d0), 64'd0);
        chk({tag, " ce/we"}, 64'({img_ce0, dus_ce0, dus_we0}), 64'd0);
        chk({tag, " ap_idle"}, 64'(ap_idle), 64'd1);
    endtask

    initial begin
        fill(0);
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Ramp image with hand-computed pins.
        start_run(1'b0);
        wait_done();
        check_run(1);
`ifdef DUS_STREAM_AVG_EN
        chk("avg dus[0]", 64'(dus_mem[0]), 64'd16);
        chk("avg dus[255]", 64'(dus_mem[255]), 64'd1006);
        chk("avg model dus[255]", 64'(exp_dus[255]), 64'd1006);
        chk("avg read count", 64'(rd_cnt), 64'd1024);
        chk("avg ap_done cycle", 64'(done_q.size() > 0 ? done_q[0] : -1), 64'd1026);
`else
        chk("dec dus[0]", 64'(dus_mem[0]), 64'd0);
        chk("dec dus[1]", 64'(dus_mem[1]), 64'd2);
        chk("dec dus[16]", 64'(dus_mem[16]), 64'd64);
        chk("dec dus[255]", 64'(dus_mem[255]), 64'd990);
        chk("dec model dus[16]", 64'(exp_dus[16]), 64'd64);
        chk("dec write count", 64'(wr_cnt), 64'd256);
        chk("dec ap_done cycle", 64'(done_q.size() > 0 ? done_q[0] : -1), 64'd258);
`endif

        // All-ones image: the mean must stay all-ones.
        fill(1);
        start_run(1'b0);
        wait_done();
        check_run(1);
        chk("all-ones dus[0]", 64'(dus_mem[0]), 64'hFFFFFFFF);
        chk("all-ones dus[N-1]", 64'(dus_mem[N-1]), 64'hFFFFFFFF);

        // Scrambled image.
        fill(2);
        start_run(1'b0);
        wait_done();
        check_run(1);

        // Start held high: back-to-back runs from the IDLE cycle after DONE.
        fill(0);
        start_run(1'b1);
        wait_done();
        wait_done();
        ap_start = 1'b0;
        chk("held ap_done pulses", 64'(done_q.size()), 64'd2);
        chk("held second read cycle", 64'(rd_begin_q.size() > 1 ? rd_begin_q[1] : -1), 64'(R + 4));
        chk("held second done cycle", 64'(done_q.size() > 1 ? done_q[1] : -1), 64'(2 * R + 5));
        chk("held write count", 64'(wr_cnt), 64'(2 * N));
`ifndef DUS_STREAM_AVG_EN
        chk("held second read cycle literal", 64'(rd_begin_q.size() > 1 ? rd_begin_q[1] : -1), 64'd260);
`endif

        // Reset sampled at cycle 100 of a run.
        start_run(1'b0);
        repeat (99) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check_quiet("mid-run reset");
        rst = 1'b0;
        repeat (R + 10) @(posedge clk);
        #1;
        chk("no ap_done after reset", 64'(done_q.size()), 64'd0);
        start_run(1'b0);
        wait_done();
        check_run(1);

        // Start pulses during RUN and DONE are ignored.
        fill(2);
        start_run(1'b0);
        repeat (50) @(posedge clk);
        #1 ap_start = 1'b1;
        @(posedge clk); #1 ap_start = 1'b0;
        for (int n = 0; n < R + 50 && !ap_done; n++) @(negedge clk);
        chk("pulse run ap_done seen", 64'(ap_done), 64'd1);
        ap_start = 1'b1;
        @(posedge clk); #1 ap_start = 1'b0;
        repeat (R + 10) @(posedge clk);
        #1;
        check_run(1);
        chk("no extra run", 64'(rd_begin_q.size()), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
